puck_controller: RTL and testbench

PUCK_CONTROLLER -- requirements
Module: puck_controller

---
 rtl/puck_controller.sv | 144 ++++++++++++++
 tb/tb_puck_controller.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/puck_controller.sv
// Bouncing-square puck: each accepted frame tick erases the puck, moves it one pixel
// diagonally with wall reflection, and redraws it, streaming one pixel per cycle.
module puck_controller #(
  parameter int unsigned SCREEN_W    = 320,
  parameter int unsigned SCREEN_H    = 240,
  parameter int unsigned SIZE        = 4,
  parameter int unsigned X_INIT      = 158,
  parameter int unsigned Y_INIT      = 118,
  parameter logic [2:0]  PUCK_COLOUR = 3'b111
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       go,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic [8:0] puck_x,
  output logic [7:0] puck_y,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StErase, StMove, StDraw} state_e;

  localparam logic [9:0] ScreenW10 = 10'(SCREEN_W);
  localparam logic [9:0] ScreenH10 = 10'(SCREEN_H);
  localparam logic [9:0] Size10    = 10'(SIZE);

  state_e     state;
  logic [3:0] cnt;
  logic       dir_x;
  logic       dir_y;
  logic       init_pending;

  logic [9:0] x_ext;
  logic [9:0] y_ext;
  logic [8:0] x_next;
  logic [7:0] y_next;
  logic       dir_x_next;
  logic       dir_y_next;
  logic       scanning;

  // Reflection is decided in 10 bits so the far-edge sum can never wrap.
  always_comb begin
    x_ext      = {1'b0, puck_x};
    y_ext      = {2'b00, puck_y};
    x_next     = puck_x;
    y_next     = puck_y;
    dir_x_next = dir_x;
    dir_y_next = dir_y;

    if (dir_x && (x_ext + Size10 == ScreenW10)) begin
      dir_x_next = 1'b0;
      x_next     = puck_x - 9'd1;
    end else if (!dir_x && (puck_x == 9'd0)) begin
      dir_x_next = 1'b1;
      x_next     = puck_x + 9'd1;
    end else if (dir_x) begin
      x_next = puck_x + 9'd1;
    end else begin
      x_next = puck_x - 9'd1;
    end

    if (dir_y && (y_ext + Size10 == ScreenH10)) begin
      dir_y_next = 1'b0;
      y_next     = puck_y - 8'd1;
    end else if (!dir_y && (puck_y == 8'd0)) begin
      dir_y_next = 1'b1;
      y_next     = puck_y + 8'd1;
    end else if (dir_y) begin
      y_next = puck_y + 8'd1;
    end else begin
      y_next = puck_y - 8'd1;
    end
  end

  assign scanning = (state == StErase) || (state == StDraw);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= StIdle;
      cnt          <= 4'd0;
      init_pending <= 1'b1;
      puck_x       <= 9'(X_INIT);
      puck_y       <= 8'(Y_INIT);
      dir_x        <= 1'b1;
      dir_y        <= 1'b1;
      plot         <= 1'b0;
      vga_x        <= 9'd0;
      vga_y        <= 8'd0;
      vga_colour   <= 3'd0;
      busy         <= 1'b0;
    end else begin
      // Outputs are a registered view of the scan state held during this cycle.
      busy <= (state != StIdle);
      plot <= scanning;
      if (scanning) begin
        vga_x      <= puck_x + {7'd0, cnt[1:0]};
        vga_y      <= puck_y + {6'd0, cnt[3:2]};
        vga_colour <= (state == StDraw) ? PUCK_COLOUR : 3'd0;
      end else begin
        vga_x      <= 9'd0;
        vga_y      <= 8'd0;
        vga_colour <= 3'd0;
      end

      unique case (state)
        StIdle: begin
          if (init_pending) begin
            init_pending <= 1'b0;
            state        <= StDraw;
            cnt          <= 4'd0;
          end else if (frame_tick && go) begin
            state <= StErase;
            cnt   <= 4'd0;
          end
        end
        StErase: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state <= StMove;
          end
        end
        StMove: begin
          puck_x <= x_next;
          puck_y <= y_next;
          dir_x  <= dir_x_next;
          dir_y  <= dir_y_next;
          cnt    <= 4'd0;
          state  <= StDraw;
        end
        StDraw: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_puck_controller.sv
// Randomised and directed bench for puck_controller: a full-size instance and a tiny 8x8
// instance share all inputs and are both checked against a frame-level model.
module tb_puck_controller;

  localparam int SZ = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0;
  logic go = 1'b0;

  logic [8:0] vx  [2];
  logic [7:0] vy  [2];
  logic [2:0] vc  [2];
  logic       pl  [2];
  logic [8:0] pxo [2];
  logic [7:0] pyo [2];
  logic       bsy [2];

  puck_controller dut_big (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .go(go),
    .vga_x(vx[0]), .vga_y(vy[0]), .vga_colour(vc[0]), .plot(pl[0]),
    .puck_x(pxo[0]), .puck_y(pyo[0]), .busy(bsy[0])
  );

  puck_controller #(
    .SCREEN_W(8), .SCREEN_H(8), .SIZE(4), .X_INIT(4), .Y_INIT(4), .PUCK_COLOUR(3'b111)
  ) dut_small (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .go(go),
    .vga_x(vx[1]), .vga_y(vy[1]), .vga_colour(vc[1]), .plot(pl[1]),
    .puck_x(pxo[1]), .puck_y(pyo[1]), .busy(bsy[1])
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Frame-level model: position, direction, expected pixel stream and busy window.
  int lim_w [2] = '{320, 8};
  int lim_h [2] = '{240, 8};
  int ini_x [2] = '{158, 4};
  int ini_y [2] = '{118, 4};
  int mx [2];
  int my [2];
  bit mdx [2];
  bit mdy [2];
  logic [19:0] q0 [$];
  logic [19:0] q1 [$];
  bit pend = 1'b0;
  bit nonidle = 1'b0;
  bit exp_busy = 1'b0;
  longint cyc = 0;
  longint free_at = 0;
  int plots [2] = '{0, 0};

  function automatic void bounce(input int p, input bit d, input int lim,
                                 output int p_o, output bit d_o);
    p_o = p;
    d_o = d;
    if (d && p + SZ == lim) begin
      d_o = 1'b0;
      p_o = p - 1;
    end else if (!d && p == 0) begin
      d_o = 1'b1;
      p_o = p + 1;
    end else begin
      p_o = d ? p + 1 : p - 1;
    end
  endfunction

  function automatic void push_scan(input int i, input int col);
    logic [19:0] p;
    for (int c = 0; c < 16; c++) begin
      p = {3'(col), 8'(my[i] + c / 4), 9'(mx[i] + c % 4)};
      if (i == 0) q0.push_back(p);
      else q1.push_back(p);
    end
  endfunction

  always @(posedge clock) begin
    int np;
    bit nd;
    cyc++;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        mx[i] = ini_x[i];
        my[i] = ini_y[i];
        mdx[i] = 1'b1;
        mdy[i] = 1'b1;
      end
      q0.delete();
      q1.delete();
      pend = 1'b1;
      nonidle = 1'b0;
      exp_busy = 1'b0;
    end else begin
      exp_busy = nonidle;
      if (pend) begin
        pend = 1'b0;
        for (int i = 0; i < 2; i++) push_scan(i, 7);
        free_at = cyc + 16;
      end else if (!nonidle && frame_tick && go) begin
        for (int i = 0; i < 2; i++) begin
          push_scan(i, 0);
          bounce(mx[i], mdx[i], lim_w[i], np, nd);
          mx[i] = np;
          mdx[i] = nd;
          bounce(my[i], mdy[i], lim_h[i], np, nd);
          my[i] = np;
          mdy[i] = nd;
          push_scan(i, 7);
        end
        free_at = cyc + 33;
      end
      nonidle = (cyc < free_at);
    end
  end

  always @(negedge clock) begin
    logic [19:0] e;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("busy%0d", i), bsy[i], exp_busy);
      if (pl[i]) begin
        plots[i]++;
        check($sformatf("x_range%0d", i), longint'(vx[i]) < lim_w[i], 1);
        check($sformatf("y_range%0d", i), longint'(vy[i]) < lim_h[i], 1);
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
          check($sformatf("spurious_plot%0d", i), 1, 0);
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("pixel%0d", i), {vc[i], vy[i], vx[i]}, e);
        end
      end else begin
        check($sformatf("idle_zero%0d", i), {vc[i], vy[i], vx[i]}, 0);
      end
      if (!nonidle && !exp_busy) begin
        check($sformatf("pos_x%0d", i), pxo[i], mx[i]);
        check($sformatf("pos_y%0d", i), pyo[i], my[i]);
      end
    end
  end

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
  endtask

  task automatic frame();
    tick();
    repeat (36) @(negedge clock);
  endtask

  initial begin
    int base;
    int x0;
    int y0;

    // Reset release paints the initial puck.
    repeat (3) @(negedge clock);
    reset = 1'b0;
    base = plots[0];
    repeat (20) @(negedge clock);
    check("init_plots", plots[0] - base, 16);
    check("init_busy", bsy[0], 0);
    check("init_x", pxo[0], 158);
    check("init_y", pyo[0], 118);

    // One accepted tick: latency and new position.
    go = 1'b1;
    base = plots[0];
    tick();
    repeat (33) @(negedge clock);
    check("busy_t33", bsy[0], 1);
    @(negedge clock);
    check("busy_t34", bsy[0], 0);
    check("frame_plots", plots[0] - base, 32);
    check("move_x", pxo[0], 159);
    check("move_y", pyo[0], 119);

    // Tick while busy is dropped; tick with go=0 is ignored.
    x0 = pxo[0];
    y0 = pyo[0];
    tick();
    repeat (4) @(negedge clock);
    tick();
    repeat (40) @(negedge clock);
    go = 1'b0;
    tick();
    repeat (40) @(negedge clock);
    check("one_update_x", pxo[0] - x0, 1);
    check("one_update_y", pyo[0] - y0, 1);

    // Reset during DRAW c=7 kills the scan and restarts the initial draw.
    go = 1'b1;
    tick();
    repeat (24) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_plot", pl[0], 0);
    check("rst_x", pxo[0], 158);
    check("rst_y", pyo[0], 118);
    reset = 1'b0;
    base = plots[0];
    repeat (20) @(negedge clock);
    check("redraw_plots", plots[0] - base, 16);

    // Random traffic including occasional resets.
    for (int k = 0; k < 3000; k++) begin
      go = ($urandom_range(0, 3) != 0);
      frame_tick = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 499) == 0);
      @(negedge clock);
    end
    frame_tick = 1'b0;
    reset = 1'b0;
    go = 1'b0;
    repeat (40) @(negedge clock);

    // Right wall on the full-size instance.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    go = 1'b1;
    for (int k = 0; k < 200 && !(mx[0] == 316 && mdx[0]); k++) frame();
    check("wall_reach", pxo[0], 316);
    frame();
    check("wall_bounce", pxo[0], 315);
    frame();
    check("wall_leave", pxo[0], 314);

    // Corner on the small instance.
    for (int k = 0; k < 20 && !(mx[1] == 0 && my[1] == 0 && !mdx[1] && !mdy[1]); k++) frame();
    check("corner_x0", pxo[1], 0);
    check("corner_y0", pyo[1], 0);
    frame();
    check("corner_x1", pxo[1], 1);
    check("corner_y1", pyo[1], 1);
    frame();
    check("corner_x2", pxo[1], 2);
    check("corner_y2", pyo[1], 2);

    go = 1'b0;
    repeat (5) @(negedge clock);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
